dalu_seq: RTL and testbench



---
 rtl/dalu_seq_if.sv | 31 +++
 rtl/dalu_seq.sv | 191 +++++++++++++++++++
 tb/tb_dalu_seq.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/dalu_seq_if.sv
// dalu_seq request/result bundle.
// Master issues start/op/operands; slave returns busy/done/results.
interface dalu_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [7:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cf;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] c;
  logic             c_flag;
  logic             z_flag;
  logic             o_flag;
  logic             dz_flag;

  modport master (
    output start, op, a, b, cf,
    input  busy, done, acc, c,
    input  c_flag, z_flag, o_flag, dz_flag
  );

  modport slave (
    input  start, op, a, b, cf,
    output busy, done, acc, c,
    output c_flag, z_flag, o_flag, dz_flag
  );
endinterface

// File: rtl/dalu_seq.sv
// Multi-cycle execute ALU: 1-cycle add/sub/cmp,
// iterative shift-add multiply and restoring divide.
module dalu_seq #(
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic     clk,
  input  logic     rst_n,
  dalu_seq_if.slave bus
);
  localparam logic [7:0] OP_ADD = 8'h1;
  localparam logic [7:0] OP_ADC = 8'h2;
  localparam logic [7:0] OP_SUB = 8'h3;
  localparam logic [7:0] OP_SUC = 8'h4;
  localparam logic [7:0] OP_MUL = 8'h5;
  localparam logic [7:0] OP_DIV = 8'h7;
  localparam logic [7:0] OP_CMP = 8'h9;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIN
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             div_q, div_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             cfl_q, cfl_d;
  logic             zf_q, zf_d;
  logic             of_q, of_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;

  logic             is_add, is_sub, is_cin;
  logic             is_mul, is_div, is_cmp;
  logic [WIDTH:0]   ea, eb, cin;
  logic [WIDTH:0]   as_sum;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_r, div_t;

  assign is_add = (bus.op == OP_ADD) || (bus.op == OP_ADC);
  assign is_sub = (bus.op == OP_SUB) || (bus.op == OP_SUC);
  assign is_cin = (bus.op == OP_ADC) || (bus.op == OP_SUC);
  assign is_mul = (bus.op == OP_MUL);
  assign is_div = (bus.op == OP_DIV);
  assign is_cmp = (bus.op == OP_CMP);

  assign ea  = {bus.a[WIDTH-1], bus.a};
  assign eb  = {bus.b[WIDTH-1], bus.b};
  assign cin = {{WIDTH{1'b0}}, bus.cf & is_cin};

  assign as_sum = is_sub ? (ea - eb - cin)
                         : (ea + eb + cin);

  // Shared hi/lo pair: product accumulator or remainder/quotient.
  assign mul_sum = {1'b0, hi_q}
                 + (lo_q[0] ? {1'b0, b_q} : '0);
  assign div_r   = {hi_q, lo_q[WIDTH-1]};
  assign div_t   = div_r - {1'b0, b_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    acc_d   = acc_q;
    c_d     = c_q;
    cfl_d   = cfl_q;
    zf_d    = zf_q;
    of_d    = of_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          unique case (1'b1)
            is_add, is_sub: begin
              acc_d  = as_sum[WIDTH-1:0];
              cfl_d  = as_sum[WIDTH];
              of_d   = as_sum[WIDTH] ^ as_sum[WIDTH-1];
              zf_d   = (as_sum[WIDTH-1:0] == '0);
              done_d = 1'b1;
            end
            is_cmp: begin
              zf_d   = (bus.a == bus.b);
              cfl_d  = (bus.a <  bus.b);
              of_d   = (bus.a >  bus.b);
              done_d = 1'b1;
            end
            is_mul, is_div: begin
              a_d     = bus.a;
              b_d     = bus.b;
              div_d   = is_div;
              hi_d    = '0;
              lo_d    = bus.a;
              cnt_d   = '0;
              state_d = ITER;
            end
            default: done_d = 1'b1;
          endcase
        end
      end
      ITER: begin
        if (div_q) begin
          hi_d = div_t[WIDTH] ? div_r[WIDTH-1:0]
                              : div_t[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], ~div_t[WIDTH]};
        end else begin
          hi_d = mul_sum[WIDTH:1];
          lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (!div_q) begin
          acc_d = lo_q;
          c_d   = hi_q;
          zf_d  = ({hi_q, lo_q} == '0);
        end else if (b_q == '0) begin
          acc_d = '1;
          c_d   = a_q;
          dz_d  = 1'b1;
          zf_d  = 1'b0;
        end else begin
          acc_d = lo_q;
          c_d   = hi_q;
          dz_d  = 1'b0;
          zf_d  = (lo_q == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      c_q     <= '0;
      cfl_q   <= 1'b0;
      zf_q    <= 1'b0;
      of_q    <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      cfl_q   <= cfl_d;
      zf_q    <= zf_d;
      of_q    <= of_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.acc     = acc_q;
  assign bus.c       = c_q;
  assign bus.c_flag  = cfl_q;
  assign bus.z_flag  = zf_q;
  assign bus.o_flag  = of_q;
  assign bus.dz_flag = dz_q;
endmodule

// File: tb/tb_dalu_seq.sv
// Directed bench for dalu_seq: arithmetic, mul/div
// latency, ignored start, back-to-back and mid-op reset.
module tb_dalu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   lat;
  logic [15:0] acc_mid;
  logic        busy_mid;

  dalu_seq_if #(.WIDTH(16)) bus ();

  dalu_seq #(.WIDTH(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {bus.c_flag, bus.z_flag, bus.o_flag, bus.dz_flag};
  endfunction

  task automatic issue(input logic [7:0] op,
                       input logic [15:0] a,
                       input logic [15:0] b,
                       input logic cf);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.cf    = cf;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic run_iter(input bit inject,
                          output int lat_o);
    lat_o = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (inject && i == 3) begin
        bus.op    = 8'h1;
        bus.a     = 16'h0001;
        bus.b     = 16'h0001;
        bus.start = 1'b1;
      end
      if (i == 4) bus.start = 1'b0;
      if (i == 5) begin
        acc_mid  = bus.acc;
        busy_mid = bus.busy;
      end
      if (bus.done) begin
        lat_o = i;
        break;
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = 8'h0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cf    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_acc", bus.acc, 0);
    chk("rst_c", bus.c, 0);
    chk("rst_flags", flags(), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(8'h1, 16'h7FFF, 16'h0001, 1'b0);
    chk("add_done", bus.done, 1);
    chk("add_busy", bus.busy, 0);
    chk("add_acc", bus.acc, 16'h8000);
    chk("add_flags", flags(), 4'b0010);
    @(posedge clk);
    #1;
    chk("add_done_pulse", bus.done, 0);

    issue(8'h2, 16'hFFFF, 16'h0000, 1'b1);
    chk("adc_acc", bus.acc, 16'h0000);
    chk("adc_flags", flags(), 4'b0100);

    issue(8'h3, 16'h0005, 16'h0005, 1'b0);
    chk("sub_acc", bus.acc, 16'h0000);
    chk("sub_flags", flags(), 4'b0100);

    issue(8'h4, 16'h0003, 16'h0001, 1'b1);
    chk("suc_acc", bus.acc, 16'h0001);
    chk("suc_flags", flags(), 4'b0000);

    issue(8'h5, 16'hFFFF, 16'hFFFF, 1'b0);
    chk("mul_busy0", bus.busy, 1);
    chk("mul_done0", bus.done, 0);
    run_iter(1'b1, lat);
    chk("mul_lat", lat, 17);
    chk("mul_busy_mid", busy_mid, 1);
    chk("mul_acc_hold", acc_mid, 16'h0001);
    chk("mul_acc", bus.acc, 16'h0001);
    chk("mul_c", bus.c, 16'hFFFE);
    chk("mul_flags", flags(), 4'b0000);
    chk("mul_busy_fin", bus.busy, 0);
    @(posedge clk);
    #1;
    chk("mul_one_done", bus.done, 0);

    issue(8'h7, 16'd1000, 16'd7, 1'b0);
    run_iter(1'b0, lat);
    chk("div_lat", lat, 17);
    chk("div_acc", bus.acc, 16'd142);
    chk("div_c", bus.c, 16'd6);
    chk("div_flags", flags(), 4'b0000);

    issue(8'h7, 16'h1234, 16'h0000, 1'b0);
    run_iter(1'b0, lat);
    chk("dz_lat", lat, 17);
    chk("dz_acc", bus.acc, 16'hFFFF);
    chk("dz_c", bus.c, 16'h1234);
    chk("dz_flags", flags(), 4'b0001);

    issue(8'h9, 16'h8000, 16'h0001, 1'b0);
    chk("cmp_gt_flags", flags(), 4'b0011);
    chk("cmp_gt_acc", bus.acc, 16'hFFFF);
    chk("cmp_gt_c", bus.c, 16'h1234);
    issue(8'h9, 16'h0055, 16'h0055, 1'b0);
    chk("cmp_eq_flags", flags(), 4'b0101);
    issue(8'h9, 16'h0001, 16'h0002, 1'b0);
    chk("cmp_lt_flags", flags(), 4'b1001);

    issue(8'h6, 16'h1111, 16'h2222, 1'b1);
    chk("undef_done", bus.done, 1);
    chk("undef_acc", bus.acc, 16'hFFFF);
    chk("undef_flags", flags(), 4'b1001);

    issue(8'h5, 16'h0000, 16'h1234, 1'b0);
    run_iter(1'b0, lat);
    chk("mul0_lat", lat, 17);
    chk("mul0_acc", bus.acc, 16'h0000);
    chk("mul0_flags", flags(), 4'b1101);
    issue(8'h1, 16'h0002, 16'h0002, 1'b0);
    chk("b2b_done", bus.done, 1);
    chk("b2b_acc", bus.acc, 16'h0004);

    issue(8'h7, 16'd1000, 16'd7, 1'b0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_acc", bus.acc, 0);
    chk("abort_c", bus.c, 0);
    chk("abort_flags", flags(), 0);
    rst_n = 1'b1;
    lat = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.done) lat++;
    end
    chk("abort_no_done", lat, 0);
    issue(8'h1, 16'd2, 16'd3, 1'b0);
    chk("post_add_acc", bus.acc, 16'd5);
    chk("post_add_done", bus.done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
